// File: rtl/upct_tree_plru_pkg.sv
// Shared UPCT sizing and update classification. Feature macro: UPCT_WRITE_BYPASS_EN.
package upct_tree_plru_pkg;

  localparam int UPCT_ENTRIES     = 8;
  localparam int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES);
  localparam int UPPER_PC_WIDTH   = 21;

  typedef enum logic [1:0] {
    UPD_HIT   = 2'd0,
    UPD_FILL  = 2'd1,
    UPD_EVICT = 2'd2
  } upd_kind_e;

  function automatic upd_kind_e classify(input logic hit, input logic any_free);
    if (hit)           return UPD_HIT;
    else if (any_free) return UPD_FILL;
    else               return UPD_EVICT;
  endfunction

endpackage

// File: rtl/upct_tree_plru_plru_tree.sv
// Heap-ordered tree-PLRU: combinational victim walk, registered touch of one leaf per cycle.
module plru_tree #(
  parameter int ENTRIES = 8,
  parameter int LOG     = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           touch_valid,
  input  logic [LOG-1:0] touch_index,
  output logic [LOG-1:0] victim
);

  logic [ENTRIES-2:0] tree;
  logic [ENTRIES-2:0] tree_next;

  // Node bit 0 sends the victim walk left; children of node n are 2n+1 and 2n+2.
  always_comb begin
    logic [ENTRIES-2:0] sh;
    int node;
    victim = '0;
    node   = 0;
    for (int lvl = 0; lvl < LOG; lvl++) begin
      sh     = tree >> node;
      victim = (victim << 1) | LOG'(sh[0]);
      node   = 2 * node + 1 + int'(sh[0]);
    end
  end

  always_comb begin
    logic [ENTRIES-2:0] one;
    logic [LOG-1:0]     ish;
    int node;
    tree_next = tree;
    one       = {{(ENTRIES-2){1'b0}}, 1'b1};
    node      = 0;
    for (int lvl = 0; lvl < LOG; lvl++) begin
      ish       = touch_index >> (LOG - 1 - lvl);
      // Point each node on the path away from the touched subtree.
      tree_next = (tree_next & ~(one << node)) | ({{(ENTRIES-2){1'b0}}, ~ish[0]} << node);
      node      = 2 * node + 1 + int'(ish[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tree <= '0;
    else if (touch_valid) tree <= tree_next;
  end

endmodule

// File: rtl/upct_tree_plru.sv
// Fully associative upper-PC table with tree-PLRU replacement. Feature macro: UPCT_WRITE_BYPASS_EN.
module upct_tree_plru
  import upct_tree_plru_pkg::*;
#(
  parameter int UPCT_ENTRIES     = upct_tree_plru_pkg::UPCT_ENTRIES,
  parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
  parameter int UPPER_PC_WIDTH   = upct_tree_plru_pkg::UPPER_PC_WIDTH
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        read_valid,
  input  logic [LOG_UPCT_ENTRIES-1:0] read_index,
  output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC,
  input  logic                        update0_valid,
  input  logic [UPPER_PC_WIDTH-1:0]   update0_upper_PC,
  output logic                        update1_valid,
  output logic                        update1_hit,
  output logic [LOG_UPCT_ENTRIES-1:0] update1_upct_index
);

  logic [UPPER_PC_WIDTH-1:0]   data [UPCT_ENTRIES];
  logic [UPCT_ENTRIES-1:0]     valid;
  logic                        hit;
  logic                        any_free;
  logic [LOG_UPCT_ENTRIES-1:0] hit_idx;
  logic [LOG_UPCT_ENTRIES-1:0] free_idx;
  logic [LOG_UPCT_ENTRIES-1:0] victim_idx;
  logic [LOG_UPCT_ENTRIES-1:0] chosen_idx;
  logic                        do_write;
  logic                        bypass;
  upd_kind_e                   kind;

  // Scan from the top down so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    any_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = UPCT_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && data[i] == update0_upper_PC) begin
        hit     = 1'b1;
        hit_idx = LOG_UPCT_ENTRIES'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = LOG_UPCT_ENTRIES'(i);
      end
    end
  end

  always_comb begin
    kind = classify(hit, any_free);
    case (kind)
      UPD_HIT:  chosen_idx = hit_idx;
      UPD_FILL: chosen_idx = free_idx;
      default:  chosen_idx = victim_idx;
    endcase
    do_write = update0_valid && (kind != UPD_HIT);
  end

`ifdef UPCT_WRITE_BYPASS_EN
  assign bypass = do_write && (chosen_idx == read_index);
`else
  assign bypass = 1'b0;
`endif

  plru_tree #(.ENTRIES(UPCT_ENTRIES), .LOG(LOG_UPCT_ENTRIES)) u_plru (
    .clk         (CLK),
    .rst_n       (nRST),
    .touch_valid (update0_valid),
    .touch_index (chosen_idx),
    .victim      (victim_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < UPCT_ENTRIES; i++) data[i] <= '0;
    end else if (do_write) begin
      valid[chosen_idx] <= 1'b1;
      data[chosen_idx]  <= update0_upper_PC;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      read_upper_PC      <= '0;
      update1_valid      <= 1'b0;
      update1_hit        <= 1'b0;
      update1_upct_index <= '0;
    end else begin
      if (read_valid) read_upper_PC <= bypass ? update0_upper_PC : data[read_index];
      update1_valid <= update0_valid;
      if (update0_valid) begin
        update1_hit        <= hit;
        update1_upct_index <= chosen_idx;
      end
    end
  end

endmodule

// File: tb/tb_upct_tree_plru.sv
// Directed self-checking bench for upct_tree_plru (8 entries); honours UPCT_WRITE_BYPASS_EN.
module tb_upct_tree_plru;

  logic        clk;
  logic        rst_n;
  logic        read_valid;
  logic [2:0]  read_index;
  logic [20:0] read_upper_pc;
  logic        update0_valid;
  logic [20:0] update0_upper_pc;
  logic        update1_valid;
  logic        update1_hit;
  logic [2:0]  update1_upct_index;

  int vectors;
  int miscompares;

  upct_tree_plru dut (
    .CLK                (clk),
    .nRST               (rst_n),
    .read_valid         (read_valid),
    .read_index         (read_index),
    .read_upper_PC      (read_upper_pc),
    .update0_valid      (update0_valid),
    .update0_upper_PC   (update0_upper_pc),
    .update1_valid      (update1_valid),
    .update1_hit        (update1_hit),
    .update1_upct_index (update1_upct_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n            = 1'b0;
    read_valid       = 1'b0;
    read_index       = '0;
    update0_valid    = 1'b0;
    update0_upper_pc = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (update1_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_update1_valid got %0b want 0", update1_valid);
    end
    vectors++;
    if (update1_hit !== 1'b0) begin
      miscompares++; $display("FAIL reset_update1_hit got %0b want 0", update1_hit);
    end
    vectors++;
    if (update1_upct_index !== 3'd0) begin
      miscompares++; $display("FAIL reset_update1_index got %0d want 0", update1_upct_index);
    end
    vectors++;
    if (read_upper_pc !== 21'd0) begin
      miscompares++; $display("FAIL reset_read_data got %h want 0", read_upper_pc);
    end
  endtask

  task automatic test_hit_repeat();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      update0_valid = 1'b1; update0_upper_pc = 21'h12345;
      @(posedge clk); #1;
      vectors++;
      if (update1_valid !== 1'b1 || update1_hit !== (k == 1) || update1_upct_index !== 3'd0) begin
        miscompares++;
        $display("FAIL hit_repeat_%0d got v=%0b h=%0b i=%0d want v=1 h=%0b i=0",
                 k, update1_valid, update1_hit, update1_upct_index, k == 1);
      end
      @(negedge clk);
    end
    update0_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (update1_valid !== 1'b0 || update1_hit !== 1'b1 || update1_upct_index !== 3'd0) begin
      miscompares++;
      $display("FAIL idle_hold got v=%0b h=%0b i=%0d want v=0 h=1 i=0",
               update1_valid, update1_hit, update1_upct_index);
    end
    @(negedge clk);
  endtask

  task automatic do_fill();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      update0_valid = 1'b1; update0_upper_pc = 21'(i + 1);
      @(posedge clk); #1;
      vectors++;
      if (update1_valid !== 1'b1 || update1_hit !== 1'b0 || update1_upct_index !== 3'(i)) begin
        miscompares++;
        $display("FAIL fill_%0d got v=%0b h=%0b i=%0d want v=1 h=0 i=%0d",
                 i, update1_valid, update1_hit, update1_upct_index, i);
      end
      @(negedge clk);
    end
    update0_valid = 1'b0;
  endtask

  task automatic test_fill_and_read();
    do_fill();
    for (int i = 0; i < 8; i++) begin
      read_valid = 1'b1; read_index = 3'(i);
      @(posedge clk); #1;
      vectors++;
      if (read_upper_pc !== 21'(i + 1)) begin
        miscompares++; $display("FAIL read_%0d got %h want %h", i, read_upper_pc, 21'(i + 1));
      end
      @(negedge clk);
    end
    read_valid = 1'b0; read_index = 3'd0;
    @(posedge clk); #1;
    vectors++;
    if (read_upper_pc !== 21'h8) begin
      miscompares++; $display("FAIL read_hold got %h want 8", read_upper_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_evict_first();
    do_fill();
    update0_valid = 1'b1; update0_upper_pc = 21'h9;
    @(posedge clk); #1;
    vectors++;
    if (update1_hit !== 1'b0 || update1_upct_index !== 3'd0) begin
      miscompares++;
      $display("FAIL evict_first got h=%0b i=%0d want h=0 i=0", update1_hit, update1_upct_index);
    end
    @(negedge clk);
    update0_valid = 1'b0; read_valid = 1'b1; read_index = 3'd0;
    @(posedge clk); #1;
    vectors++;
    if (read_upper_pc !== 21'h9) begin
      miscompares++; $display("FAIL evict_first_read got %h want 9", read_upper_pc);
    end
    @(negedge clk);
    read_valid = 1'b0;
  endtask

  task automatic test_plru_victim();
    do_fill();
    update0_valid = 1'b1; update0_upper_pc = 21'h1;
    @(posedge clk); #1;
    vectors++;
    if (update1_hit !== 1'b1 || update1_upct_index !== 3'd0) begin
      miscompares++;
      $display("FAIL touch_hit got h=%0b i=%0d want h=1 i=0", update1_hit, update1_upct_index);
    end
    @(negedge clk);
    update0_upper_pc = 21'h9;
    @(posedge clk); #1;
    vectors++;
    if (update1_hit !== 1'b0 || update1_upct_index !== 3'd4) begin
      miscompares++;
      $display("FAIL plru_victim got h=%0b i=%0d want h=0 i=4", update1_hit, update1_upct_index);
    end
    @(negedge clk);
    update0_valid = 1'b0; read_valid = 1'b1; read_index = 3'd4;
    @(posedge clk); #1;
    vectors++;
    if (read_upper_pc !== 21'h9) begin
      miscompares++; $display("FAIL plru_victim_read got %h want 9", read_upper_pc);
    end
    @(negedge clk);
    read_valid = 1'b0;
  endtask

  task automatic test_same_cycle_read();
    logic [20:0] want;
`ifdef UPCT_WRITE_BYPASS_EN
    want = 21'h9;
`else
    want = 21'h1;
`endif
    do_fill();
    update0_valid = 1'b1; update0_upper_pc = 21'h9;
    read_valid = 1'b1; read_index = 3'd0;
    @(posedge clk); #1;
    vectors++;
    if (read_upper_pc !== want) begin
      miscompares++; $display("FAIL same_cycle_read got %h want %h", read_upper_pc, want);
    end
    vectors++;
    if (update1_hit !== 1'b0 || update1_upct_index !== 3'd0) begin
      miscompares++;
      $display("FAIL same_cycle_update got h=%0b i=%0d want h=0 i=0", update1_hit, update1_upct_index);
    end
    @(negedge clk);
    update0_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (read_upper_pc !== 21'h9) begin
      miscompares++; $display("FAIL after_write_read got %h want 9", read_upper_pc);
    end
    @(negedge clk);
    read_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    update0_valid = 1'b1; update0_upper_pc = 21'h12;
    @(negedge clk);
    update0_upper_pc = 21'h34; read_valid = 1'b1; read_index = 3'd0;
    @(posedge clk); #2;
    vectors++;
    if (update1_valid !== 1'b1 || update1_upct_index !== 3'd1 || read_upper_pc !== 21'h12) begin
      miscompares++;
      $display("FAIL pre_reset got v=%0b i=%0d r=%h want v=1 i=1 r=12",
               update1_valid, update1_upct_index, read_upper_pc);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (update1_valid !== 1'b0 || update1_hit !== 1'b0 || update1_upct_index !== 3'd0 ||
        read_upper_pc !== 21'd0) begin
      miscompares++;
      $display("FAIL async_reset got v=%0b h=%0b i=%0d r=%h want all 0",
               update1_valid, update1_hit, update1_upct_index, read_upper_pc);
    end
    read_valid = 1'b0; update0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    update0_valid = 1'b1; update0_upper_pc = 21'h7;
    @(posedge clk); #1;
    vectors++;
    if (update1_valid !== 1'b1 || update1_hit !== 1'b0 || update1_upct_index !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_update got v=%0b h=%0b i=%0d want v=1 h=0 i=0",
               update1_valid, update1_hit, update1_upct_index);
    end
    @(negedge clk);
    update0_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_hit_repeat();
    test_fill_and_read();
    test_evict_first();
    test_plru_victim();
    test_same_cycle_read();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
